// File: rtl/rpn_controller.sv
// rpn_controller -- keypad-to-stack sequencer for an RPN calculator.
// Turns key tokens (digits, enter, add/sub/mul, clear) into one-cycle
// write/push/pop strobes for an external stack and tracks the entry mode.
//
// Ports:
//   clock, reset                  clock and synchronous active-high reset
//   key_valid/key_ready           token handshake (accept when both high)
//   key_type[2:0], key_digit[3:0] token code and digit value
//   stk_write/stk_push/stk_pop    registered one-cycle stack strobes
//   stk_value[31:0]               data for stk_write (0 when not writing)
//   stk_top/stk_next/stk_count    current stack view
//   stk_error                     stack overflow/underflow flag
//   error                         sticky error, cleared by a clear token
//   busy                          inverse of key_ready
module rpn_controller (
  input  logic        clock,
  input  logic        reset,
  input  logic        key_valid,
  output logic        key_ready,
  input  logic [2:0]  key_type,
  input  logic [3:0]  key_digit,
  output logic        stk_write,
  output logic        stk_push,
  output logic        stk_pop,
  output logic [31:0] stk_value,
  input  logic [31:0] stk_top,
  input  logic [31:0] stk_next,
  input  logic [5:0]  stk_count,
  input  logic        stk_error,
  output logic        error,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_LIFT_WR, S_OP_POP, S_OP_WR} state_t;
  typedef enum logic [1:0] {M_REPLACE, M_APPEND, M_LIFT} mode_t;

  state_t      r_state, w_state_next;
  mode_t       r_mode, w_mode_next;
  logic        r_error, w_error_next;
  logic        r_write, w_write_next;
  logic        r_push, w_push_next;
  logic        r_pop, w_pop_next;
  logic [31:0] r_value, w_value_next;
  // Operand held across a multi-cycle command: operator result or LIFT digit.
  logic [31:0] r_hold, w_hold_next;
  // A LIFT digit's push has been issued and its write is still owed.
  logic        r_pend, w_pend_next;
  // A strobe was high last cycle, so stk_error now reflects that operation.
  logic        r_strobe_d;

  logic        w_ready, w_accept, w_exec, w_guard;
  logic        w_is_digit, w_is_enter, w_is_op, w_is_clear;
  logic [31:0] w_op_result, w_append_value;

  assign w_is_digit = (key_type == 3'd0);
  assign w_is_enter = (key_type == 3'd1);
  assign w_is_op    = (key_type == 3'd2) || (key_type == 3'd3) || (key_type == 3'd4);
  assign w_is_clear = (key_type == 3'd5);

  assign w_guard = (key_type[2:1] == 2'b11)
                || (w_is_digit && (key_digit > 4'd9))
                || (w_is_op && (stk_count == 6'd0))
                || ((w_is_enter || (w_is_digit && (r_mode == M_LIFT))) && (stk_count == 6'd63));

  assign w_ready  = (r_state == S_IDLE) && !r_pend;
  assign w_accept = key_valid && w_ready;
  // Token that actually produces stack activity.
  assign w_exec   = w_accept && !w_is_clear && !r_error && !w_guard;

  always_comb begin
    w_op_result = stk_next + stk_top;
    if (key_type == 3'd3)
      w_op_result = stk_next - stk_top;
    else if (key_type == 3'd4)
      w_op_result = stk_next * stk_top;
  end

  assign w_append_value = (stk_top * 32'd10) + {28'd0, key_digit};

  // State register
  always_ff @(posedge clock) begin
    if (reset)
      r_state <= S_IDLE;
    else
      r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (r_pend)
          w_state_next = S_LIFT_WR;
        else if (w_exec && w_is_op)
          w_state_next = S_OP_POP;
      end
      S_OP_POP:  w_state_next = S_OP_WR;
      S_OP_WR:   w_state_next = S_IDLE;
      S_LIFT_WR: w_state_next = S_IDLE;
      default:   w_state_next = S_IDLE;
    endcase
  end

  // Output logic: next values of the registered strobes and control state
  always_comb begin
    w_write_next = 1'b0;
    w_push_next  = 1'b0;
    w_pop_next   = 1'b0;
    w_value_next = 32'd0;
    w_mode_next  = r_mode;
    w_error_next = r_error;
    w_pend_next  = 1'b0;
    w_hold_next  = r_hold;
    if (r_strobe_d && stk_error)
      w_error_next = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (r_pend) begin
          w_write_next = 1'b1;
          w_value_next = r_hold;
        end else if (w_accept) begin
          if (w_is_clear) begin
            w_error_next = 1'b0;
            w_mode_next  = M_REPLACE;
          end else if (!r_error && w_guard) begin
            w_error_next = 1'b1;
          end else if (w_exec) begin
            if (w_is_digit) begin
              case (r_mode)
                M_REPLACE: begin
                  w_write_next = 1'b1;
                  w_value_next = {28'd0, key_digit};
                  w_mode_next  = M_APPEND;
                end
                M_APPEND: begin
                  w_write_next = 1'b1;
                  w_value_next = w_append_value;
                end
                default: begin
                  w_push_next = 1'b1;
                  w_pend_next = 1'b1;
                  w_hold_next = {28'd0, key_digit};
                  w_mode_next = M_APPEND;
                end
              endcase
            end else if (w_is_enter) begin
              w_push_next = 1'b1;
              w_mode_next = M_REPLACE;
            end else begin
              w_pop_next  = 1'b1;
              w_hold_next = w_op_result;
              w_mode_next = M_LIFT;
            end
          end
        end
      end
      S_OP_POP: begin
        w_write_next = 1'b1;
        w_value_next = r_hold;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_mode     <= M_REPLACE;
      r_error    <= 1'b0;
      r_write    <= 1'b0;
      r_push     <= 1'b0;
      r_pop      <= 1'b0;
      r_value    <= 32'd0;
      r_hold     <= 32'd0;
      r_pend     <= 1'b0;
      r_strobe_d <= 1'b0;
    end else begin
      r_mode     <= w_mode_next;
      r_error    <= w_error_next;
      r_write    <= w_write_next;
      r_push     <= w_push_next;
      r_pop      <= w_pop_next;
      r_value    <= w_value_next;
      r_hold     <= w_hold_next;
      r_pend     <= w_pend_next;
      r_strobe_d <= r_write || r_push || r_pop;
    end
  end

  assign key_ready = w_ready;
  assign busy      = !w_ready;
  assign stk_write = r_write;
  assign stk_push  = r_push;
  assign stk_pop   = r_pop;
  assign stk_value = r_value;
  assign error     = r_error;

endmodule

// File: tb/tb_rpn_controller.sv
// Self-checking bench for rpn_controller: a table of single tokens with
// hand-computed strobe sequences, plus hand-written multi-cycle sequences
// (wrap-around, overflow guards, stack error, reset mid-command).
module tb_rpn_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic        key_valid;
  logic        key_ready;
  logic [2:0]  key_type;
  logic [3:0]  key_digit;
  logic        stk_write, stk_push, stk_pop;
  logic [31:0] stk_value;
  logic [31:0] stk_top, stk_next;
  logic [5:0]  stk_count;
  logic        stk_error;
  logic        error, busy;

  rpn_controller dut (
    .clock(clock), .reset(reset),
    .key_valid(key_valid), .key_ready(key_ready),
    .key_type(key_type), .key_digit(key_digit),
    .stk_write(stk_write), .stk_push(stk_push), .stk_pop(stk_pop),
    .stk_value(stk_value),
    .stk_top(stk_top), .stk_next(stk_next), .stk_count(stk_count),
    .stk_error(stk_error),
    .error(error), .busy(busy)
  );

  always #5 clock = ~clock;

  // Behavioural stack driven by the strobes; presets let the bench
  // place arbitrary contents before a test.
  logic [31:0] m_top;
  logic [5:0]  m_cnt;
  logic [31:0] m_below [64];
  logic        pre_req = 1'b0;
  logic [5:0]  pre_cnt = 6'd0;
  logic [31:0] pre_top = 32'd0, pre_next = 32'd0;
  logic        force_err = 1'b0;

  always @(posedge clock) begin
    if (reset) begin
      m_top <= 32'd0;
      m_cnt <= 6'd0;
    end else if (pre_req) begin
      m_cnt <= pre_cnt;
      m_top <= pre_top;
      if (pre_cnt != 6'd0) m_below[pre_cnt - 6'd1] <= pre_next;
    end else begin
      if (stk_write) m_top <= stk_value;
      if (stk_push && m_cnt != 6'd63) begin
        m_below[m_cnt] <= m_top;
        m_cnt <= m_cnt + 6'd1;
      end
      if (stk_pop && m_cnt != 6'd0) begin
        m_top <= m_below[m_cnt - 6'd1];
        m_cnt <= m_cnt - 6'd1;
      end
    end
  end

  assign stk_top   = m_top;
  assign stk_next  = (m_cnt != 6'd0) ? m_below[m_cnt - 6'd1] : 32'd0;
  assign stk_count = m_cnt;
  assign stk_error = force_err;

  localparam logic [2:0] EV_N = 3'd0, EV_W = 3'd1, EV_P = 3'd2, EV_O = 3'd3, EV_X = 3'd4;
  localparam logic [2:0] K_D = 3'd0, K_E = 3'd1, K_A = 3'd2, K_S = 3'd3, K_M = 3'd4, K_C = 3'd5;

  typedef struct {
    logic [2:0]  kt;
    logic [3:0]  kd;
    logic [2:0]  ev1;
    logic [2:0]  ev2;
    logic [31:0] val;
    logic        err;
    logic        busy1;
  } vec_t;

  int checks = 0;
  int failures = 0;
  logic [31:0] last_val;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] ev_of();
    int n;
    n = int'(stk_write) + int'(stk_push) + int'(stk_pop);
    if (n > 1) return EV_X;
    if (stk_write) return EV_W;
    if (stk_push) return EV_P;
    if (stk_pop) return EV_O;
    return EV_N;
  endfunction

  // Sample one cycle at the falling edge and check the per-cycle invariants.
  task automatic sample(input string tag, output logic [2:0] ev);
    @(negedge clock);
    ev = ev_of();
    if (stk_write) last_val = stk_value;
    else chk({tag, "_value_zero"}, stk_value, 32'd0);
    chk({tag, "_busy_inv"}, {31'd0, busy}, {31'd0, !key_ready});
  endtask

  task automatic send_key(input logic [2:0] t, input logic [3:0] d);
    int n;
    n = 0;
    @(negedge clock);
    while (!key_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (!key_ready) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout actual=0 required=1");
    end
    key_type = t;
    key_digit = d;
    key_valid = 1'b1;
    @(posedge clock);
    #1;
    key_valid = 1'b0;
    key_type = 3'd0;
    key_digit = 4'd0;
  endtask

  task automatic run_vec(input string name, input vec_t v);
    logic [2:0] e1, e2, e3;
    logic b1;
    last_val = 32'd0;
    send_key(v.kt, v.kd);
    sample({name, "_c1"}, e1);
    b1 = busy;
    sample({name, "_c2"}, e2);
    sample({name, "_c3"}, e3);
    $display("%s type=%0d digit=%0d ev=%0d/%0d/%0d val=%h err=%0d busy1=%0d",
             name, v.kt, v.kd, e1, e2, e3, last_val, error, b1);
    chk({name, "_ev1"}, {29'd0, e1}, {29'd0, v.ev1});
    chk({name, "_ev2"}, {29'd0, e2}, {29'd0, v.ev2});
    chk({name, "_ev3"}, {29'd0, e3}, {29'd0, EV_N});
    chk({name, "_val"}, last_val, v.val);
    chk({name, "_err"}, {31'd0, error}, {31'd0, v.err});
    chk({name, "_busy1"}, {31'd0, b1}, {31'd0, v.busy1});
    chk({name, "_ready"}, {31'd0, key_ready}, 32'd1);
  endtask

  task automatic preset(input logic [5:0] c, input logic [31:0] t, input logic [31:0] n);
    @(negedge clock);
    pre_cnt = c;
    pre_top = t;
    pre_next = n;
    pre_req = 1'b1;
    @(posedge clock);
    #1;
    pre_req = 1'b0;
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_ready"}, {31'd0, key_ready}, 32'd1);
    chk({name, "_busy"}, {31'd0, busy}, 32'd0);
    chk({name, "_error"}, {31'd0, error}, 32'd0);
    chk({name, "_strobes"}, {29'd0, stk_write, stk_push, stk_pop}, 32'd0);
    chk({name, "_value"}, stk_value, 32'd0);
  endtask

  vec_t vt [25];

  initial begin
    vt[0]  = '{K_D, 4'd1,  EV_W, EV_N, 32'd1,   1'b0, 1'b0};
    vt[1]  = '{K_D, 4'd2,  EV_W, EV_N, 32'd12,  1'b0, 1'b0};
    vt[2]  = '{K_D, 4'd3,  EV_W, EV_N, 32'd123, 1'b0, 1'b0};
    vt[3]  = '{K_C, 4'd0,  EV_N, EV_N, 32'd0,   1'b0, 1'b0};
    vt[4]  = '{K_D, 4'd7,  EV_W, EV_N, 32'd7,   1'b0, 1'b0};
    vt[5]  = '{K_E, 4'd0,  EV_P, EV_N, 32'd0,   1'b0, 1'b0};
    vt[6]  = '{K_D, 4'd5,  EV_W, EV_N, 32'd5,   1'b0, 1'b0};
    vt[7]  = '{K_A, 4'd0,  EV_O, EV_W, 32'd12,  1'b0, 1'b1};
    vt[8]  = '{K_C, 4'd0,  EV_N, EV_N, 32'd0,   1'b0, 1'b0};
    vt[9]  = '{K_D, 4'd6,  EV_W, EV_N, 32'd6,   1'b0, 1'b0};
    vt[10] = '{K_E, 4'd0,  EV_P, EV_N, 32'd0,   1'b0, 1'b0};
    vt[11] = '{K_D, 4'd7,  EV_W, EV_N, 32'd7,   1'b0, 1'b0};
    vt[12] = '{K_M, 4'd0,  EV_O, EV_W, 32'd42,  1'b0, 1'b1};
    vt[13] = '{K_D, 4'd4,  EV_P, EV_W, 32'd4,   1'b0, 1'b1};
    vt[14] = '{K_S, 4'd0,  EV_O, EV_W, 32'd38,  1'b0, 1'b1};
    vt[15] = '{K_A, 4'd0,  EV_N, EV_N, 32'd0,   1'b1, 1'b0};
    vt[16] = '{K_D, 4'd5,  EV_N, EV_N, 32'd0,   1'b1, 1'b0};
    vt[17] = '{K_C, 4'd0,  EV_N, EV_N, 32'd0,   1'b0, 1'b0};
    vt[18] = '{K_D, 4'd9,  EV_W, EV_N, 32'd9,   1'b0, 1'b0};
    vt[19] = '{K_D, 4'd10, EV_N, EV_N, 32'd0,   1'b1, 1'b0};
    vt[20] = '{K_C, 4'd0,  EV_N, EV_N, 32'd0,   1'b0, 1'b0};
    vt[21] = '{3'd6, 4'd0, EV_N, EV_N, 32'd0,   1'b1, 1'b0};
    vt[22] = '{K_C, 4'd0,  EV_N, EV_N, 32'd0,   1'b0, 1'b0};
    vt[23] = '{3'd7, 4'd0, EV_N, EV_N, 32'd0,   1'b1, 1'b0};
    vt[24] = '{K_C, 4'd0,  EV_N, EV_N, 32'd0,   1'b0, 1'b0};

    reset = 1'b1;
    key_valid = 1'b0;
    key_type = 3'd0;
    key_digit = 4'd0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk_idle("reset_state");
    reset = 1'b0;

    for (int i = 0; i < 25; i++) begin
      run_vec($sformatf("vec%0d", i), vt[i]);
      if (i == 13) begin
        chk("lift_top", stk_top, 32'd4);
        chk("lift_next", stk_next, 32'd42);
      end
    end

    // APPEND wrap-around: 0xFFFFFFFF*10+9 mod 2^32
    run_vec("wrap_d1", '{K_D, 4'd1, EV_W, EV_N, 32'd1, 1'b0, 1'b0});
    preset(6'd0, 32'hFFFF_FFFF, 32'd0);
    run_vec("wrap_d9", '{K_D, 4'd9, EV_W, EV_N, 32'hFFFF_FFFF, 1'b0, 1'b0});

    // Full-stack guards for enter and for a LIFT digit
    preset(6'd63, 32'd5, 32'd6);
    run_vec("full_enter", '{K_E, 4'd0, EV_N, EV_N, 32'd0, 1'b1, 1'b0});
    run_vec("full_clr1", '{K_C, 4'd0, EV_N, EV_N, 32'd0, 1'b0, 1'b0});
    preset(6'd1, 32'd3, 32'd6);
    run_vec("mul_18", '{K_M, 4'd0, EV_O, EV_W, 32'd18, 1'b0, 1'b1});
    preset(6'd63, 32'd18, 32'd6);
    run_vec("full_lift", '{K_D, 4'd2, EV_N, EV_N, 32'd0, 1'b1, 1'b0});
    run_vec("full_clr2", '{K_C, 4'd0, EV_N, EV_N, 32'd0, 1'b0, 1'b0});

    // Subtraction wrap: 3 - 5
    preset(6'd1, 32'd5, 32'd3);
    run_vec("sub_wrap", '{K_S, 4'd0, EV_O, EV_W, 32'hFFFF_FFFE, 1'b0, 1'b1});
    run_vec("sub_clr", '{K_C, 4'd0, EV_N, EV_N, 32'd0, 1'b0, 1'b0});

    // stk_error only counts in the cycle after a strobe
    force_err = 1'b1;
    run_vec("serr_clr", '{K_C, 4'd0, EV_N, EV_N, 32'd0, 1'b0, 1'b0});
    run_vec("serr_d4", '{K_D, 4'd4, EV_W, EV_N, 32'd4, 1'b1, 1'b0});
    force_err = 1'b0;
    run_vec("serr_clr2", '{K_C, 4'd0, EV_N, EV_N, 32'd0, 1'b0, 1'b0});

    // Reset during OP_POP: the OP_WR write must never appear
    preset(6'd1, 32'd2, 32'd3);
    send_key(K_A, 4'd0);
    @(negedge clock);
    chk("rst_mid_pop", {31'd0, stk_pop}, 32'd1);
    reset = 1'b1;
    @(negedge clock);
    chk_idle("rst_mid_c2");
    reset = 1'b0;
    @(negedge clock);
    chk_idle("rst_mid_c3");
    $display("rst_mid add aborted write=%0d ready=%0d", stk_write, key_ready);
    run_vec("rst_mode", '{K_D, 4'd8, EV_W, EV_N, 32'd8, 1'b0, 1'b0});

    // Token offered while reset is high is not accepted
    @(negedge clock);
    reset = 1'b1;
    key_valid = 1'b1;
    key_type = K_D;
    key_digit = 4'd5;
    repeat (3) @(negedge clock);
    chk_idle("rst_tok_hold");
    reset = 1'b0;
    key_valid = 1'b0;
    key_digit = 4'd0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      chk($sformatf("rst_tok_c%0d", c), {29'd0, stk_write, stk_push, stk_pop}, 32'd0);
    end
    $display("rst_tok token during reset ignored");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
